// File: rtl/mem_port_arbiter.sv
// Arbiter that lets the fetch and load/store ports share one single-port memory.
// Define ARB_TIMEOUT_EN to abandon an access when mem_ack does not arrive within TIMEOUT cycles.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_amp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_amp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              arb_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  if (TIMEOUT < 1) begin : gBadTimeout
    $error("mem_port_arbiter: TIMEOUT must be at least 1");
  end

  logic [1:0]        state_q, state_d;
  logic              memReq_q, memReq_d;
  logic              memWe_q, memWe_d;
  logic [3:0]        memAmp_q, memAmp_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;
  logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
  logic [DATA_W-1:0] dRdata_q, dRdata_d;
  logic              ifValid_q, ifValid_d;
  logic              dValid_q, dValid_d;
  logic              maskI_q, maskI_d;
  logic              maskD_q, maskD_d;
  logic              grantI, grantD;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cntInc;
  logic             arbErr_q, arbErr_d;
  assign cntInc = cnt_q + 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAmp_d   = memAmp_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    ifRdata_d  = ifRdata_q;
    dRdata_d   = dRdata_q;
    ifValid_d  = 1'b0;
    dValid_d   = 1'b0;
    maskI_d    = maskI_q;
    maskD_d    = maskD_q;
    grantI     = 1'b0;
    grantD     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    arbErr_d   = 1'b0;
`endif
    // On completion the served port is implicitly masked: only the other port may chain in.
    case (state_q)
      BUSY_I: begin
        if (mem_ack) begin
          ifValid_d = 1'b1;
          ifRdata_d = mem_rdata;
          state_d   = IDLE;
          memReq_d  = 1'b0;
          grantD    = d_req;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cntInc == TIMEOUT_C) begin
          ifValid_d = 1'b1;
          ifRdata_d = '0;
          arbErr_d  = 1'b1;
          maskI_d   = 1'b1;
          state_d   = IDLE;
          memReq_d  = 1'b0;
        end else begin
          cnt_d = cntInc;
        end
`endif
      end
      BUSY_D: begin
        if (mem_ack) begin
          dValid_d = 1'b1;
          if (!memWe_q) dRdata_d = mem_rdata;
          state_d  = IDLE;
          memReq_d = 1'b0;
          grantI   = if_req;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cntInc == TIMEOUT_C) begin
          dValid_d = 1'b1;
          dRdata_d = '0;
          arbErr_d = 1'b1;
          maskD_d  = 1'b1;
          state_d  = IDLE;
          memReq_d = 1'b0;
        end else begin
          cnt_d = cntInc;
        end
`endif
      end
      default: begin
        grantD  = d_req & ~maskD_q;
        grantI  = if_req & ~maskI_q & ~grantD;
        maskI_d = 1'b0;
        maskD_d = 1'b0;
      end
    endcase

    if (grantD) begin
      state_d    = BUSY_D;
      memReq_d   = 1'b1;
      memWe_d    = d_we;
      memAmp_d   = d_amp;
      memAddr_d  = d_addr;
      memWdata_d = d_wdata;
`ifdef ARB_TIMEOUT_EN
      cnt_d      = '0;
`endif
    end else if (grantI) begin
      state_d   = BUSY_I;
      memReq_d  = 1'b1;
      memWe_d   = 1'b0;
      memAmp_d  = 4'b1111;
      memAddr_d = if_addr;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAmp_q   <= 4'b0000;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      ifRdata_q  <= '0;
      dRdata_q   <= '0;
      ifValid_q  <= 1'b0;
      dValid_q   <= 1'b0;
      maskI_q    <= 1'b0;
      maskD_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAmp_q   <= memAmp_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      ifRdata_q  <= ifRdata_d;
      dRdata_q   <= dRdata_d;
      ifValid_q  <= ifValid_d;
      dValid_q   <= dValid_d;
      maskI_q    <= maskI_d;
      maskD_q    <= maskD_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      arbErr_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      arbErr_q <= arbErr_d;
    end
  end
  assign arb_err = arbErr_q;
`else
  assign arb_err = 1'b0;
`endif

  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_amp   = memAmp_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign if_rdata  = ifRdata_q;
  assign d_rdata   = dRdata_q;
  assign if_valid  = ifValid_q;
  assign d_valid   = dValid_q;
  assign if_stall  = if_req & ~ifValid_q;
  assign d_stall   = d_req & ~dValid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the timeout scenario follows ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall;
  logic        d_req, d_we;
  logic [3:0]  d_amp;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_valid, d_stall;
  logic        mem_req, mem_we;
  logic [3:0]  mem_amp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, arb_err;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_amp(d_amp), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_amp(mem_amp), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .arb_err(arb_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #12;
    vecCount++;
    if ({mem_req, mem_we, mem_amp, if_valid, d_valid, arb_err} !== 9'h0) begin
      $display("[TB] FAIL reset_ctrl actual=%h expected=000", {mem_req, mem_we, mem_amp, if_valid, d_valid, arb_err});
      missCount++;
    end
    vecCount++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
      $display("[TB] FAIL reset_data actual=%h expected=0", {mem_addr, mem_wdata, if_rdata, d_rdata});
      missCount++;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_fetch;
    if_req  = 1'b1;
    if_addr = 32'h0000_0004;
    tick();
    vecCount++;
    if ({mem_req, mem_we, mem_amp, mem_addr, if_stall} !== {1'b1, 1'b0, 4'hF, 32'h4, 1'b1}) begin
      $display("[TB] FAIL fetch_grant actual=%h expected=%h", {mem_req, mem_we, mem_amp, mem_addr, if_stall}, {1'b1, 1'b0, 4'hF, 32'h4, 1'b1});
      missCount++;
    end
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h0050_0093;
    tick();
    vecCount++;
    if ({if_valid, if_rdata, if_stall, mem_req} !== {1'b1, 32'h0050_0093, 1'b0, 1'b0}) begin
      $display("[TB] FAIL fetch_done actual=%h expected=%h", {if_valid, if_rdata, if_stall, mem_req}, {1'b1, 32'h0050_0093, 1'b0, 1'b0});
      missCount++;
    end
    if_req  = 1'b0;
    mem_ack = 1'b0;
    tick();
    vecCount++;
    if ({if_valid, mem_req} !== 2'b00) begin
      $display("[TB] FAIL fetch_pulse_once actual=%b expected=00", {if_valid, mem_req});
      missCount++;
    end
  endtask

  task automatic test_contention;
    if_req  = 1'b1;
    if_addr = 32'h0000_0200;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0100;
    d_wdata = 32'hDEAD_BEEF;
    d_amp   = 4'b0011;
    tick();
    vecCount++;
    if ({mem_req, mem_we, mem_amp, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF}) begin
      $display("[TB] FAIL cont_data_first actual=%h expected=%h", {mem_req, mem_we, mem_amp, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF});
      missCount++;
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_1111;
    tick();
    vecCount++;
    if ({d_valid, if_valid, mem_req, mem_we, mem_amp, mem_addr, d_rdata} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0}) begin
      $display("[TB] FAIL cont_chain_fetch actual=%h expected=%h", {d_valid, if_valid, mem_req, mem_we, mem_amp, mem_addr, d_rdata}, {1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0});
      missCount++;
    end
    d_req     = 1'b0;
    mem_rdata = 32'h2222_2222;
    tick();
    vecCount++;
    if ({if_valid, d_valid, if_rdata, mem_req} !== {1'b1, 1'b0, 32'h2222_2222, 1'b0}) begin
      $display("[TB] FAIL cont_fetch_done actual=%h expected=%h", {if_valid, d_valid, if_rdata, mem_req}, {1'b1, 1'b0, 32'h2222_2222, 1'b0});
      missCount++;
    end
    if_req  = 1'b0;
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] expAddr, expData;
    bit          isD;
    if_req  = 1'b1;
    if_addr = 32'h0000_0400;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_amp   = 4'hF;
    d_addr  = 32'h0000_0300;
    tick();
    mem_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      isD     = (k % 2 == 0);
      expAddr = isD ? 32'h300 : 32'h400;
      expData = 32'hA000_0000 + 32'(k);
      vecCount++;
      if ({mem_req, mem_addr} !== {1'b1, expAddr}) begin
        $display("[TB] FAIL b2b_grant%0d actual=%h expected=%h", k, {mem_req, mem_addr}, {1'b1, expAddr});
        missCount++;
      end
      mem_rdata = expData;
      if (k == 5) d_req = 1'b0;
      tick();
      vecCount++;
      if (isD && {d_valid, if_valid, d_rdata} !== {1'b1, 1'b0, expData}) begin
        $display("[TB] FAIL b2b_dvalid%0d actual=%h expected=%h", k, {d_valid, if_valid, d_rdata}, {1'b1, 1'b0, expData});
        missCount++;
      end else if (!isD && {if_valid, d_valid, if_rdata} !== {1'b1, 1'b0, expData}) begin
        $display("[TB] FAIL b2b_ivalid%0d actual=%h expected=%h", k, {if_valid, d_valid, if_rdata}, {1'b1, 1'b0, expData});
        missCount++;
      end
    end
    vecCount++;
    if (mem_req !== 1'b0) begin
      $display("[TB] FAIL b2b_idle actual=%b expected=0", mem_req);
      missCount++;
    end
    if_req  = 1'b0;
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0500;
    tick();
    d_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    vecCount++;
    if ({mem_req, mem_addr, d_rdata, if_rdata, d_valid} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      $display("[TB] FAIL rst_mid_clear actual=%h expected=0", {mem_req, mem_addr, d_rdata, if_rdata, d_valid});
      missCount++;
    end
    #2;
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0055;
    tick();
    vecCount++;
    if ({d_valid, mem_req, d_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      $display("[TB] FAIL rst_stray_ack actual=%h expected=0", {d_valid, mem_req, d_rdata});
      missCount++;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_drop_req;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0600;
    tick();
    tick();
    d_req = 1'b0;
    tick();
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0066;
    tick();
    vecCount++;
    if ({d_valid, d_rdata, mem_req, d_stall} !== {1'b1, 32'h66, 1'b0, 1'b0}) begin
      $display("[TB] FAIL drop_valid actual=%h expected=%h", {d_valid, d_rdata, mem_req, d_stall}, {1'b1, 32'h66, 1'b0, 1'b0});
      missCount++;
    end
    tick();
    vecCount++;
    if ({d_valid, if_valid, mem_req} !== 3'b000) begin
      $display("[TB] FAIL idle_ack_ignored actual=%b expected=000", {d_valid, if_valid, mem_req});
      missCount++;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_timeout;
    if_req  = 1'b1;
    if_addr = 32'h0000_0700;
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      vecCount++;
      if ({mem_req, arb_err, if_valid} !== 3'b100) begin
        $display("[TB] FAIL to_wait%0d actual=%b expected=100", c, {mem_req, arb_err, if_valid});
        missCount++;
      end
    end
`ifdef ARB_TIMEOUT_EN
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0800;
    tick();
    vecCount++;
    if ({mem_req, arb_err, if_valid, if_rdata} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      $display("[TB] FAIL to_fire actual=%h expected=%h", {mem_req, arb_err, if_valid, if_rdata}, {1'b0, 1'b1, 1'b1, 32'h0});
      missCount++;
    end
    if_req = 1'b0;
    tick();
    vecCount++;
    if ({mem_req, mem_addr, arb_err, if_valid} !== {1'b1, 32'h800, 1'b0, 1'b0}) begin
      $display("[TB] FAIL to_next_grant actual=%h expected=%h", {mem_req, mem_addr, arb_err, if_valid}, {1'b1, 32'h800, 1'b0, 1'b0});
      missCount++;
    end
    d_req     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0088;
    tick();
    vecCount++;
    if ({d_valid, d_rdata} !== {1'b1, 32'h88}) begin
      $display("[TB] FAIL to_data_done actual=%h expected=%h", {d_valid, d_rdata}, {1'b1, 32'h88});
      missCount++;
    end
`else
    for (int c = 0; c < 16; c++) tick();
    vecCount++;
    if ({mem_req, arb_err, if_valid, mem_addr} !== {1'b1, 1'b0, 1'b0, 32'h700}) begin
      $display("[TB] FAIL no_to_wait actual=%h expected=%h", {mem_req, arb_err, if_valid, mem_addr}, {1'b1, 1'b0, 1'b0, 32'h700});
      missCount++;
    end
    if_req    = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0077;
    tick();
    vecCount++;
    if ({if_valid, if_rdata, mem_req} !== {1'b1, 32'h77, 1'b0}) begin
      $display("[TB] FAIL no_to_done actual=%h expected=%h", {if_valid, if_rdata, mem_req}, {1'b1, 32'h77, 1'b0});
      missCount++;
    end
`endif
    mem_ack = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_amp     = 4'h0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    test_reset();
    test_fetch();
    test_contention();
    test_back_to_back();
    test_reset_mid_access();
    test_drop_req();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
